// File: rtl/layer_stream_driver.sv
// Streams an N-word input vector to a fully-connected layer over valid/ready and
// collects its M result words into a readable buffer, reporting completion and run length.
module layer_stream_driver #(
   parameter int N = 8,
   parameter int M = 6,
   parameter int T = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_en,
   input  logic [$clog2(N)-1:0] load_addr,
   input  logic [T-1:0]         load_data,
   input  logic                 start,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [T-1:0]         tx_data,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   input  logic [T-1:0]         rx_data,
   input  logic                 rx_hold,
   input  logic [$clog2(M)-1:0] rd_addr,
   output logic [T-1:0]         rd_data,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          cycles
);

   localparam int AW = $clog2(N);
   localparam int RW = $clog2(M);
   localparam logic [AW:0]   N_LIM   = (AW+1)'(N);
   localparam logic [RW:0]   M_LIM   = (RW+1)'(M);
   localparam logic [AW-1:0] TX_LAST = AW'(N-1);
   localparam logic [RW-1:0] RX_LAST = RW'(M-1);
   localparam logic [15:0]   CYC_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_RECV = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [T-1:0]  xbuf_r [N];
   logic [T-1:0]  ybuf_r [M];
   logic [AW-1:0] tx_idx_r;
   logic [RW-1:0] rx_idx_r;
   logic [15:0]   cycles_r;
   logic [T-1:0]  rd_data_r;
   logic          tx_valid_s;
   logic          rx_ready_s;
   logic          busy_s;
   logic          done_s;
   logic          tx_fire_s;
   logic          rx_fire_s;
   logic          run_start_s;
   logic          x_wr_s;

   assign tx_fire_s   = tx_valid_s & tx_ready;
   assign rx_fire_s   = rx_valid & rx_ready_s;
   assign run_start_s = (state_r == ST_IDLE) & start;
   assign x_wr_s      = (state_r == ST_IDLE) & load_en & ({1'b0, load_addr} < N_LIM);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_SEND;
            else       state_nxt_s = ST_IDLE;
         end
         ST_SEND: begin
            if (tx_fire_s && (tx_idx_r == TX_LAST)) state_nxt_s = ST_RECV;
            else                                     state_nxt_s = ST_SEND;
         end
         ST_RECV: begin
            if (rx_fire_s && (rx_idx_r == RX_LAST)) state_nxt_s = ST_DONE;
            else                                     state_nxt_s = ST_RECV;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode; rx_ready follows rx_hold combinationally so backpressure is immediate
   always_comb begin
      tx_valid_s = 1'b0;
      rx_ready_s = 1'b0;
      busy_s     = 1'b0;
      done_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            tx_valid_s = 1'b0;
         end
         ST_SEND: begin
            tx_valid_s = 1'b1;
            busy_s     = 1'b1;
         end
         ST_RECV: begin
            rx_ready_s = ~rx_hold;
            busy_s     = 1'b1;
         end
         ST_DONE: begin
            done_s = 1'b1;
         end
         default: begin
            done_s = 1'b0;
         end
      endcase
   end

   // Word indices and saturating run-length counter
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_idx_r <= {AW{1'b0}};
         rx_idx_r <= {RW{1'b0}};
         cycles_r <= 16'd0;
      end else if (run_start_s) begin
         tx_idx_r <= {AW{1'b0}};
         rx_idx_r <= {RW{1'b0}};
         cycles_r <= 16'd0;
      end else begin
         if (tx_fire_s) begin
            tx_idx_r <= (tx_idx_r == TX_LAST) ? {AW{1'b0}} : tx_idx_r + AW'(1);
         end
         if (rx_fire_s) begin
            rx_idx_r <= (rx_idx_r == RX_LAST) ? {RW{1'b0}} : rx_idx_r + RW'(1);
         end
         if (busy_s && (cycles_r != CYC_MAX)) begin
            cycles_r <= cycles_r + 16'd1;
         end
      end
   end

   // Input vector storage; deliberately not reset
   always_ff @(posedge clk) begin
      if (x_wr_s) begin
         xbuf_r[load_addr] <= load_data;
      end
   end

   // Result storage; deliberately not reset so partial results survive an abort
   always_ff @(posedge clk) begin
      if (rx_fire_s && !reset) begin
         ybuf_r[rx_idx_r] <= rx_data;
      end
   end

   // Registered result read port; out-of-range addresses read as zero
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_r <= {T{1'b0}};
      end else if ({1'b0, rd_addr} < M_LIM) begin
         rd_data_r <= ybuf_r[rd_addr];
      end else begin
         rd_data_r <= {T{1'b0}};
      end
   end

   assign tx_valid = tx_valid_s;
   assign tx_data  = xbuf_r[tx_idx_r];
   assign rx_ready = rx_ready_s;
   assign rd_data  = rd_data_r;
   assign busy     = busy_s;
   assign done     = done_s;
   assign cycles   = cycles_r;

endmodule
